tapped_line_buffer: RTL

Parametrised multi-tap line buffer, the successor to the fixed-spacing partition line buffer on the filtered-data path. It delays a stream of filtered samples and presents `pNoTaps` equally spaced taps at once. The spacing is programmable at run time (up to `pMaxSpacing`), and fill tracking qualifies the taps. A `taps_valid` flag tells the downstream partition logic when every tap holds real data, which replaces guess-by-latency priming. A synchronous `clear` re-primes the buffer between projections.

---
 rtl/tapped_line_buffer.sv | 109 ++++++++++
 1 files changed

// File: rtl/tapped_line_buffer.sv
// Multi-tap line buffer: tap 0 register plus pNoTaps-1 circular segments sharing one
// write pointer, with run-time tap spacing and fill qualification of the taps.
module tapped_line_buffer #(
   parameter int pNoTaps      = 4,
   parameter int pMaxSpacing  = 8,
   parameter int pPtrLength   = (pMaxSpacing > 1) ? $clog2(pMaxSpacing) : 1,
   parameter int pDataLength  = 8,
   parameter int pCountLength = $clog2((pNoTaps - 1) * pMaxSpacing + 2)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clear,
   input  logic [pPtrLength:0]             spacing,
   input  logic                            enable,
   input  logic [pDataLength-1:0]          shift_in,
   output logic [pDataLength*pNoTaps-1:0]  taps,
   output logic                            taps_valid,
   output logic [pCountLength-1:0]         fill_level
);

   localparam logic [pPtrLength:0] MAX_S = (pPtrLength + 1)'(pMaxSpacing);

   typedef enum logic {ST_LOAD, ST_RUN} state_t;

   state_t                  state_q, state_d;
   logic                    load;
   logic [pPtrLength:0]     s_eff, s_clamp, s_cur, ptr_last;
   logic [pPtrLength-1:0]   wr_ptr;
   logic [pDataLength-1:0]  tap0;
   logic [pDataLength-1:0]  mem [pNoTaps-1][pMaxSpacing];
   logic [pCountLength-1:0] fill_q, fill_tgt, fill_inc;
   logic                    valid_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_LOAD;
      else       state_q <= state_d;
   end

   // The first cycle out of reset latches spacing even without a clear.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         ST_LOAD: begin
            load    = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: state_d = ST_RUN;
         default: state_d = ST_LOAD;
      endcase
   end

   // On the load cycle the freshly clamped spacing already governs wrap and fill target.
   always_comb begin
      s_clamp = spacing;
      if (spacing == '0)          s_clamp = (pPtrLength + 1)'(1);
      else if (spacing > MAX_S)   s_clamp = MAX_S;
      s_cur    = load ? s_clamp : s_eff;
      ptr_last = s_cur - (pPtrLength + 1)'(1);
      fill_tgt = pCountLength'((pNoTaps - 1) * int'(s_cur) + 1);
      fill_inc = fill_q + pCountLength'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_eff   <= MAX_S;
         wr_ptr  <= '0;
         tap0    <= '0;
         fill_q  <= '0;
         valid_q <= 1'b0;
      end else if (clear) begin
         s_eff   <= s_clamp;
         wr_ptr  <= '0;
         tap0    <= '0;
         fill_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (load) s_eff <= s_clamp;
         if (enable) begin
            tap0   <= shift_in;
            wr_ptr <= ({1'b0, wr_ptr} == ptr_last) ? '0 : wr_ptr + 1'b1;
            if (fill_q != fill_tgt) begin
               fill_q  <= fill_inc;
               valid_q <= (fill_inc == fill_tgt);
            end
         end
      end
   end

   // Segment k pushes out its oldest entry to segment k+1 in the same slot it refills.
   always_ff @(posedge clk) begin
      if (enable && !clear && !reset) begin
         mem[0][wr_ptr] <= tap0;
         for (int unsigned k = 1; k < pNoTaps - 1; k++)
            mem[k][wr_ptr] <= mem[k-1][wr_ptr];
      end
   end

   always_comb begin
      taps = '0;
      taps[pDataLength-1:0] = tap0;
      for (int unsigned k = 1; k < pNoTaps; k++)
         taps[k*pDataLength +: pDataLength] = mem[k-1][wr_ptr];
   end

   assign taps_valid = valid_q;
   assign fill_level = fill_q;

endmodule
